// File: rtl/uc_io_pkg.sv
// -----------------------------------------------------------------------------
// uc_io_pkg
//   Shared definitions for the 8-bit uC port block:
//     - port_addr_e : register address map seen by the CPU bus
//     - reg_req_t   : one-cycle CPU access request (write/read strobes + address)
//     - TRIS_RST_DEF: default direction-register reset value (all pads released)
// -----------------------------------------------------------------------------
package uc_io_pkg;

    typedef enum logic [2:0] {
        ADDR_PORTA = 3'd0,
        ADDR_PORTB = 3'd1,
        ADDR_PORTC = 3'd2,
        ADDR_TRISA = 3'd3,
        ADDR_TRISB = 3'd4,
        ADDR_TRISC = 3'd5,
        ADDR_IOCEN = 3'd6,
        ADDR_RSVD  = 3'd7
    } port_addr_e;

    typedef struct packed {
        logic       wr;
        logic       rd;
        port_addr_e addr;
    } reg_req_t;

    localparam logic [7:0] TRIS_RST_DEF = 8'hFF;
    localparam logic [7:0] IOC_MASK_DEF = 8'hF0;

endpackage

// File: rtl/io_sync.sv
// -----------------------------------------------------------------------------
// io_sync
//   W-bit, STAGES-deep flop chain that brings asynchronous pad values into
//   the clk domain. Synchronous active-low reset clears every stage.
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous reset, active-low
//   d      in   W  asynchronous pad value
//   q      out  W  synchronised value (STAGES cycles behind d)
// -----------------------------------------------------------------------------
module io_sync #(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [STAGES-1:0][W-1:0] stage_q;
    logic [STAGES-1:0][W-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/port_ctrl.sv
// -----------------------------------------------------------------------------
// port_ctrl
//   Port/TRIS register file for the 8-bit uC, sitting directly upstream of the
//   tri-state pad block. Holds the PORTA/B/C output latches and TRISA/B/C
//   direction registers, synchronises pad inputs for CPU reads, and (optionally)
//   flags changes on the upper PORTB inputs.
//
// Build option:
//   PORT_IOC_EN  defined   -> IOCEN register, PORTB snapshot, change detect and
//                             sticky rbif flag are built.
//                undefined -> none of that logic exists; rbif is tied 0,
//                             addr 6 reads 0, writes to addr 6 are dropped.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   addr, wr_en, wr_data    CPU write (one-cycle strobe)
//   rd_en, rd_data          CPU read; rd_data registered, holds when idle
//   pin_a/b/c               asynchronous pad values
//   port_int_a/b/c          output latches to pad block
//   trisa/b/c               direction to pad block (1 = input)
//   rbif, rbif_clr          sticky PORTB change flag and its clear
// -----------------------------------------------------------------------------
module port_ctrl
    import uc_io_pkg::*;
#(
    parameter int           W           = 8,
    parameter int           SYNC_STAGES = 2,
    parameter logic [W-1:0] TRIS_RST    = W'(TRIS_RST_DEF),
    parameter logic [W-1:0] IOC_MASK    = W'(IOC_MASK_DEF)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   addr,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    input  logic [W-1:0] pin_a,
    input  logic [W-1:0] pin_b,
    input  logic [W-1:0] pin_c,
    output logic [W-1:0] port_int_a,
    output logic [W-1:0] port_int_b,
    output logic [W-1:0] port_int_c,
    output logic [W-1:0] trisa,
    output logic [W-1:0] trisb,
    output logic [W-1:0] trisc,
    output logic         rbif,
    input  logic         rbif_clr
);

    reg_req_t req;
    assign req = '{wr: wr_en, rd: rd_en, addr: port_addr_e'(addr)};

    // ---------------------------------------------------------------- pad sync
    logic [W-1:0] sync_a, sync_b, sync_c;

    io_sync #(.W(W), .STAGES(SYNC_STAGES)) u_sync_a (
        .clk(clk), .rst_n(rst_n), .d(pin_a), .q(sync_a));
    io_sync #(.W(W), .STAGES(SYNC_STAGES)) u_sync_b (
        .clk(clk), .rst_n(rst_n), .d(pin_b), .q(sync_b));
    io_sync #(.W(W), .STAGES(SYNC_STAGES)) u_sync_c (
        .clk(clk), .rst_n(rst_n), .d(pin_c), .q(sync_c));

    // ----------------------------------------------------------- register file
    logic [W-1:0] porta_q, porta_d;
    logic [W-1:0] portb_q, portb_d;
    logic [W-1:0] portc_q, portc_d;
    logic [W-1:0] trisa_q, trisa_d;
    logic [W-1:0] trisb_q, trisb_d;
    logic [W-1:0] trisc_q, trisc_d;
    logic [W-1:0] rd_data_q, rd_data_d;

    // IOCEN value as seen by the read mux; constant 0 when the feature is absent.
    logic [W-1:0] iocen_rd;

    always_comb begin
        porta_d   = porta_q;
        portb_d   = portb_q;
        portc_d   = portc_q;
        trisa_d   = trisa_q;
        trisb_d   = trisb_q;
        trisc_d   = trisc_q;
        rd_data_d = rd_data_q;

        if (req.wr) begin
            case (req.addr)
                ADDR_PORTA: porta_d = wr_data;
                ADDR_PORTB: portb_d = wr_data;
                ADDR_PORTC: portc_d = wr_data;
                ADDR_TRISA: trisa_d = wr_data;
                ADDR_TRISB: trisb_d = wr_data;
                ADDR_TRISC: trisc_d = wr_data;
                default:    ; // IOCEN handled in the IOC block, addr 7 dropped
            endcase
        end

        // Read mux uses current (_q) values, so a same-edge write is not seen.
        // PORTx reads return the pad, not the latch.
        if (req.rd) begin
            case (req.addr)
                ADDR_PORTA: rd_data_d = sync_a;
                ADDR_PORTB: rd_data_d = sync_b;
                ADDR_PORTC: rd_data_d = sync_c;
                ADDR_TRISA: rd_data_d = trisa_q;
                ADDR_TRISB: rd_data_d = trisb_q;
                ADDR_TRISC: rd_data_d = trisc_q;
                ADDR_IOCEN: rd_data_d = iocen_rd;
                default:    rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            porta_q   <= '0;
            portb_q   <= '0;
            portc_q   <= '0;
            trisa_q   <= TRIS_RST;
            trisb_q   <= TRIS_RST;
            trisc_q   <= TRIS_RST;
            rd_data_q <= '0;
        end else begin
            porta_q   <= porta_d;
            portb_q   <= portb_d;
            portc_q   <= portc_d;
            trisa_q   <= trisa_d;
            trisb_q   <= trisb_d;
            trisc_q   <= trisc_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign port_int_a = porta_q;
    assign port_int_b = portb_q;
    assign port_int_c = portc_q;
    assign trisa      = trisa_q;
    assign trisb      = trisb_q;
    assign trisc      = trisc_q;
    assign rd_data    = rd_data_q;

    // -------------------------------------------------------- interrupt-on-change
`ifdef PORT_IOC_EN
    logic [W-1:0] iocen_q, iocen_d;
    logic [W-1:0] snap_q, snap_d;
    logic         rbif_q, rbif_d;
    logic [W-1:0] mism;

    // Only enabled input pins in the monitored window can flag; driven
    // outputs (tris=0) are masked so the CPU's own writes never trigger.
    assign mism = (sync_b ^ snap_q) & IOC_MASK & iocen_q & trisb_q;

    always_comb begin
        iocen_d = iocen_q;
        snap_d  = snap_q;
        if (req.wr && req.addr == ADDR_IOCEN) iocen_d = wr_data;
        // Reading PORTB re-arms the comparator against the current pad state.
        if (req.rd && req.addr == ADDR_PORTB) snap_d = sync_b;
        // Set dominates clear: a standing mismatch keeps the flag up.
        rbif_d = (rbif_q & ~rbif_clr) | (|mism);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iocen_q <= '0;
            snap_q  <= '0;
            rbif_q  <= 1'b0;
        end else begin
            iocen_q <= iocen_d;
            snap_q  <= snap_d;
            rbif_q  <= rbif_d;
        end
    end

    assign iocen_rd = iocen_q;
    assign rbif     = rbif_q;
`else
    logic unused_ioc;
    assign unused_ioc = rbif_clr ^ (|IOC_MASK);
    assign iocen_rd   = '0;
    assign rbif       = 1'b0;
`endif

endmodule

// File: tb/tb_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_port_ctrl
//   Directed self-checking bench for port_ctrl. PORTA pads are looped back from
//   the output latch; PORTB/PORTC pads are driven by the bench. IOC scenarios
//   are compiled in only when PORT_IOC_EN is defined; otherwise the bench
//   checks that the feature is inert.
// -----------------------------------------------------------------------------
module tb_port_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   addr = '0;
    logic         wr_en = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         rd_en = 1'b0;
    logic [W-1:0] rd_data;
    logic [W-1:0] pin_a;
    logic [W-1:0] pin_b = '0;
    logic [W-1:0] pin_c = '0;
    logic [W-1:0] port_int_a, port_int_b, port_int_c;
    logic [W-1:0] trisa, trisb, trisc;
    logic         rbif;
    logic         rbif_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // PORTA pads follow the latch, as if the pad block is driving them.
    assign pin_a = port_int_a;

    port_ctrl #(.W(W), .SYNC_STAGES(2), .TRIS_RST(8'hFF), .IOC_MASK(8'hF0)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .pin_a(pin_a), .pin_b(pin_b), .pin_c(pin_c),
        .port_int_a(port_int_a), .port_int_b(port_int_b), .port_int_c(port_int_c),
        .trisa(trisa), .trisb(trisb), .trisc(trisc), .rbif(rbif), .rbif_clr(rbif_clr));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
        addr = a; wr_data = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        addr = a; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_checks++;
        if (trisa !== 8'hFF || trisb !== 8'hFF || trisc !== 8'hFF) begin
            n_errors++;
            $display("FAIL reset_tris: got %h/%h/%h expected ff/ff/ff", trisa, trisb, trisc);
        end
        n_checks++;
        if (port_int_a !== 8'h00 || port_int_b !== 8'h00 || port_int_c !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_port: got %h/%h/%h expected 00/00/00", port_int_a, port_int_b, port_int_c);
        end
        n_checks++;
        if (rbif !== 1'b0 || rd_data !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_rbif_rd: got rbif=%b rd=%h expected 0/00", rbif, rd_data);
        end
        rst_n = 1'b1;
        rd(3'd4);
        n_checks++;
        if (rd_data !== 8'hFF) begin
            n_errors++;
            $display("FAIL reset_trisb_read: got %h expected ff", rd_data);
        end
    endtask

    task automatic test_drive();
        wr(3'd3, 8'h00);
        wr(3'd0, 8'hA5);
        n_checks++;
        if (port_int_a !== 8'hA5 || trisa !== 8'h00) begin
            n_errors++;
            $display("FAIL drive_latch: got port=%h tris=%h expected a5/00", port_int_a, trisa);
        end
        tick(); tick();
        rd(3'd0);
        n_checks++;
        if (rd_data !== 8'hA5) begin
            n_errors++;
            $display("FAIL drive_readback: got %h expected a5", rd_data);
        end
        // PORTC read returns pad value, not the latch.
        wr(3'd2, 8'h3C);
        pin_c = 8'hC3;
        tick(); tick();
        rd(3'd2);
        n_checks++;
        if (rd_data !== 8'hC3 || port_int_c !== 8'h3C) begin
            n_errors++;
            $display("FAIL portc_pin_read: got rd=%h latch=%h expected c3/3c", rd_data, port_int_c);
        end
    endtask

    task automatic test_same_edge();
        wr(3'd5, 8'h0F);
        addr = 3'd5; wr_data = 8'h33; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        n_checks++;
        if (rd_data !== 8'h0F || trisc !== 8'h33) begin
            n_errors++;
            $display("FAIL same_edge: got rd=%h trisc=%h expected 0f/33", rd_data, trisc);
        end
        rd(3'd5);
        n_checks++;
        if (rd_data !== 8'h33) begin
            n_errors++;
            $display("FAIL same_edge_next: got %h expected 33", rd_data);
        end
        tick(); tick();
        n_checks++;
        if (rd_data !== 8'h33) begin
            n_errors++;
            $display("FAIL rd_hold: got %h expected 33", rd_data);
        end
    endtask

    task automatic test_reserved();
        wr(3'd7, 8'h99);
        n_checks++;
        if (port_int_a !== 8'hA5 || port_int_c !== 8'h3C || trisa !== 8'h00 ||
            trisb !== 8'hFF || trisc !== 8'h33 || port_int_b !== 8'h00) begin
            n_errors++;
            $display("FAIL rsvd_write: got %h %h %h %h %h %h expected a5 00 3c 00 ff 33",
                     port_int_a, port_int_b, port_int_c, trisa, trisb, trisc);
        end
        rd(3'd7);
        n_checks++;
        if (rd_data !== 8'h00) begin
            n_errors++;
            $display("FAIL rsvd_read: got %h expected 00", rd_data);
        end
    endtask

    task automatic test_iocen_reg();
        logic [W-1:0] exp;
`ifdef PORT_IOC_EN
        exp = 8'hF0;
`else
        exp = 8'h00;
`endif
        wr(3'd6, 8'hF0);
        rd(3'd6);
        n_checks++;
        if (rd_data !== exp) begin
            n_errors++;
            $display("FAIL iocen_read: got %h expected %h", rd_data, exp);
        end
    endtask

`ifdef PORT_IOC_EN
    task automatic test_ioc();
        rd(3'd1);                     // snapshot = 00
        pin_b = 8'h40;
        tick(); tick();
        n_checks++;
        if (rbif !== 1'b0) begin
            n_errors++;
            $display("FAIL ioc_early: got %b expected 0", rbif);
        end
        tick();
        n_checks++;
        if (rbif !== 1'b1) begin
            n_errors++;
            $display("FAIL ioc_set: got %b expected 1", rbif);
        end
        rd(3'd1);                     // snapshot = 40
        n_checks++;
        if (rd_data !== 8'h40) begin
            n_errors++;
            $display("FAIL ioc_portb_read: got %h expected 40", rd_data);
        end
        rbif_clr = 1'b1; tick(); rbif_clr = 1'b0;
        n_checks++;
        if (rbif !== 1'b0) begin
            n_errors++;
            $display("FAIL ioc_clear: got %b expected 0", rbif);
        end
        pin_b = 8'h42;                // bit 1 outside IOC window
        repeat (4) tick();
        n_checks++;
        if (rbif !== 1'b0) begin
            n_errors++;
            $display("FAIL ioc_low_bit: got %b expected 0", rbif);
        end
        wr(3'd4, 8'hBF);              // bit 6 becomes an output
        pin_b = 8'h02;
        repeat (4) tick();
        n_checks++;
        if (rbif !== 1'b0) begin
            n_errors++;
            $display("FAIL ioc_output_bit: got %b expected 0", rbif);
        end
    endtask

    task automatic test_clear_race();
        wr(3'd4, 8'hFF);              // bit 6 input again: standing mismatch 40 vs 02
        tick();
        n_checks++;
        if (rbif !== 1'b1) begin
            n_errors++;
            $display("FAIL race_set: got %b expected 1", rbif);
        end
        rbif_clr = 1'b1; tick(); rbif_clr = 1'b0;
        n_checks++;
        if (rbif !== 1'b1) begin
            n_errors++;
            $display("FAIL race_set_wins: got %b expected 1", rbif);
        end
        rd(3'd1);
        rbif_clr = 1'b1; tick(); rbif_clr = 1'b0;
        n_checks++;
        if (rbif !== 1'b0) begin
            n_errors++;
            $display("FAIL race_read_clear: got %b expected 0", rbif);
        end
    endtask
`else
    task automatic test_no_ioc();
        pin_b = 8'hF0;
        repeat (4) tick();
        rbif_clr = 1'b1; tick(); rbif_clr = 1'b0;
        pin_b = 8'h0F;
        repeat (4) tick();
        n_checks++;
        if (rbif !== 1'b0) begin
            n_errors++;
            $display("FAIL no_ioc_rbif: got %b expected 0", rbif);
        end
    endtask
`endif

    task automatic test_reset_mid();
`ifdef PORT_IOC_EN
        pin_b = 8'h82;                // bit 7 toggles against snapshot 02
        repeat (3) tick();
        n_checks++;
        if (rbif !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_pre_rbif: got %b expected 1", rbif);
        end
`endif
        wr(3'd0, 8'h5A);
        n_checks++;
        if (port_int_a !== 8'h5A) begin
            n_errors++;
            $display("FAIL mid_pre_porta: got %h expected 5a", port_int_a);
        end
        // Reset lands on an edge that also carries a write and a read.
        rst_n = 1'b0; addr = 3'd3; wr_data = 8'h00; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0; rst_n = 1'b1;
        n_checks++;
        if (port_int_a !== 8'h00 || port_int_c !== 8'h00 || trisa !== 8'hFF ||
            trisb !== 8'hFF || trisc !== 8'hFF || rbif !== 1'b0 || rd_data !== 8'h00) begin
            n_errors++;
            $display("FAIL mid_reset: got a=%h c=%h ta=%h tb=%h tc=%h rbif=%b rd=%h expected 00 00 ff ff ff 0 00",
                     port_int_a, port_int_c, trisa, trisb, trisc, rbif, rd_data);
        end
        rd(3'd6);
        n_checks++;
        if (rd_data !== 8'h00) begin
            n_errors++;
            $display("FAIL mid_iocen: got %h expected 00", rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_drive();
        test_same_edge();
        test_reserved();
        test_iocen_reg();
`ifdef PORT_IOC_EN
        test_ioc();
        test_clear_race();
`else
        test_no_ioc();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
